// File: rtl/spi_pixel_loader.sv
// SPI mode-0 slave: loads a greyscale frame into pixel RAM, waits for the dither
// engine, then streams the processed frame back to the master on MISO.
module spi_pixel_loader #(
  parameter int IMAGE_SIZE       = 4096,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        spi_clk,
  input  logic                        spi_mosi,
  input  logic                        spi_cs,
  output logic                        spi_miso,
  output logic [RGB_SIZE-1:0]         pix_data,
  output logic                        pix_we,
  output logic [IMAGE_ADDR_WIDTH-1:0] pix_waddr,
  output logic                        pix_re,
  output logic [IMAGE_ADDR_WIDTH-1:0] pix_raddr,
  input  logic [RGB_SIZE-1:0]         rd_data,
  input  logic                        done_compute,
  output logic                        load_done,
  output logic                        unload_done,
  output logic                        frame_err
);

  localparam int BCW = (RGB_SIZE > 1) ? $clog2(RGB_SIZE) : 1;
  localparam logic [BCW-1:0]              BIT_LAST  = BCW'(RGB_SIZE - 1);
  localparam logic [BCW-1:0]              BIT_ONE   = BCW'(1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] ADDR_LAST = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] ADDR_ONE  = IMAGE_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_WAIT   = 2'd1,
    S_UNLOAD = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0]      sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]      mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0]      cs_sync_q, cs_sync_d;
  logic                        sck_rise_q, sck_rise_d, sck_fall_q, sck_fall_d;
  logic                        cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;
  logic                        mosi_q, mosi_d;
  state_e                      state_q, state_d;
  logic                        armed_q, armed_d;
  logic [BCW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [RGB_SIZE-1:0]         rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, tx_next_q, tx_next_d;
  logic                        tx_first_q, tx_first_d, byte_end_q, byte_end_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [IMAGE_ADDR_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic                        spi_miso_q, spi_miso_d;
  logic [RGB_SIZE-1:0]         pix_data_q, pix_data_d;
  logic                        pix_we_q, pix_we_d, pix_re_q, pix_re_d;
  logic [IMAGE_ADDR_WIDTH-1:0] pix_waddr_q, pix_waddr_d, pix_raddr_q, pix_raddr_d;
  logic                        load_done_q, load_done_d, unload_done_q, unload_done_d;
  logic                        frame_err_q, frame_err_d;
  logic                        byte_done_s;

  // Next-state logic: synchronizers, edge pulses, bit/byte framing and the load/unload FSM.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sck_rise_d  = sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
    sck_fall_d  = ~sck_sync_q[SYNC_STAGES-2] & sck_sync_q[SYNC_STAGES-1];
    cs_fall_d   = ~cs_sync_q[SYNC_STAGES-2] & cs_sync_q[SYNC_STAGES-1];
    cs_rise_d   = cs_sync_q[SYNC_STAGES-2] & ~cs_sync_q[SYNC_STAGES-1];
    mosi_d      = mosi_sync_q[SYNC_STAGES-1];

    state_d       = state_q;
    armed_d       = armed_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    tx_next_d     = tx_next_q;
    tx_first_d    = tx_first_q;
    byte_end_d    = byte_end_q;
    rd_valid_d    = pix_re_q;
    byte_cnt_d    = byte_cnt_q;
    pix_data_d    = pix_data_q;
    pix_we_d      = 1'b0;
    pix_waddr_d   = pix_waddr_q;
    pix_re_d      = 1'b0;
    pix_raddr_d   = pix_raddr_q;
    load_done_d   = load_done_q;
    unload_done_d = unload_done_q;
    frame_err_d   = frame_err_q;
    byte_done_s   = 1'b0;

    // A bit coinciding with cs_fall is dropped; one coinciding with cs_rise still counts.
    if (armed_q && sck_rise_q && !cs_fall_q) begin
      rx_sr_d = {rx_sr_q[RGB_SIZE-2:0], mosi_q};
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d   = '0;
        byte_done_s = 1'b1;
      end else begin
        bit_cnt_d   = bit_cnt_q + BIT_ONE;
      end
    end else begin
      rx_sr_d = rx_sr_q;
    end

    if (cs_fall_q) begin
      armed_d   = 1'b1;
      bit_cnt_d = '0;
    end else if (cs_rise_q) begin
      armed_d = 1'b0;
      if (bit_cnt_d != '0) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = frame_err_q;
      end
      bit_cnt_d = '0;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      S_LOAD: begin
        if (byte_done_s) begin
          pix_data_d  = {rx_sr_q[RGB_SIZE-2:0], mosi_q};
          pix_we_d    = 1'b1;
          pix_waddr_d = byte_cnt_q;
        end else begin
          pix_we_d    = 1'b0;
        end
        if (pix_we_q) begin
          if (pix_waddr_q == ADDR_LAST) begin
            state_d     = S_WAIT;
            load_done_d = 1'b1;
            byte_cnt_d  = '0;
          end else begin
            byte_cnt_d  = byte_cnt_q + ADDR_ONE;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      S_WAIT: begin
        if (done_compute) begin
          pix_re_d    = 1'b1;
          pix_raddr_d = '0;
          tx_first_d  = 1'b1;
          byte_end_d  = 1'b0;
          state_d     = S_UNLOAD;
        end else begin
          state_d     = S_WAIT;
        end
      end
      S_UNLOAD: begin
        // First read fills the shifter directly; later reads prefetch the following byte.
        if (rd_valid_q) begin
          if (tx_first_q) begin
            tx_sr_d    = rd_data;
            tx_first_d = 1'b0;
            if (pix_raddr_q != ADDR_LAST) begin
              pix_re_d    = 1'b1;
              pix_raddr_d = pix_raddr_q + ADDR_ONE;
            end else begin
              pix_re_d    = 1'b0;
            end
          end else begin
            tx_next_d = rd_data;
          end
        end else begin
          tx_next_d = tx_next_q;
        end
        if (armed_q && sck_fall_q) begin
          if (byte_end_q) begin
            tx_sr_d    = tx_next_q;
            byte_end_d = 1'b0;
            if (pix_raddr_q != ADDR_LAST) begin
              pix_re_d    = 1'b1;
              pix_raddr_d = pix_raddr_q + ADDR_ONE;
            end else begin
              pix_re_d    = 1'b0;
            end
          end else begin
            tx_sr_d = {tx_sr_q[RGB_SIZE-2:0], 1'b0};
          end
        end else begin
          byte_end_d = byte_end_q;
        end
        if (byte_done_s) begin
          if (byte_cnt_q == ADDR_LAST) begin
            state_d       = S_DONE;
            unload_done_d = 1'b1;
          end else begin
            byte_cnt_d    = byte_cnt_q + ADDR_ONE;
            byte_end_d    = 1'b1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    if ((state_d == S_UNLOAD) && armed_d) begin
      spi_miso_d = tx_sr_d[RGB_SIZE-1];
    end else begin
      spi_miso_d = 1'b0;
    end
  end

  // State and output registers; synchronizers reset low so a held-low CS never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      cs_sync_q     <= '0;
      sck_rise_q    <= 1'b0;
      sck_fall_q    <= 1'b0;
      cs_fall_q     <= 1'b0;
      cs_rise_q     <= 1'b0;
      mosi_q        <= 1'b0;
      state_q       <= S_LOAD;
      armed_q       <= 1'b0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      tx_next_q     <= '0;
      tx_first_q    <= 1'b0;
      byte_end_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      byte_cnt_q    <= '0;
      spi_miso_q    <= 1'b0;
      pix_data_q    <= '0;
      pix_we_q      <= 1'b0;
      pix_waddr_q   <= '0;
      pix_re_q      <= 1'b0;
      pix_raddr_q   <= '0;
      load_done_q   <= 1'b0;
      unload_done_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_sync_q     <= cs_sync_d;
      sck_rise_q    <= sck_rise_d;
      sck_fall_q    <= sck_fall_d;
      cs_fall_q     <= cs_fall_d;
      cs_rise_q     <= cs_rise_d;
      mosi_q        <= mosi_d;
      state_q       <= state_d;
      armed_q       <= armed_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      tx_next_q     <= tx_next_d;
      tx_first_q    <= tx_first_d;
      byte_end_q    <= byte_end_d;
      rd_valid_q    <= rd_valid_d;
      byte_cnt_q    <= byte_cnt_d;
      spi_miso_q    <= spi_miso_d;
      pix_data_q    <= pix_data_d;
      pix_we_q      <= pix_we_d;
      pix_waddr_q   <= pix_waddr_d;
      pix_re_q      <= pix_re_d;
      pix_raddr_q   <= pix_raddr_d;
      load_done_q   <= load_done_d;
      unload_done_q <= unload_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign spi_miso    = spi_miso_q;
  assign pix_data    = pix_data_q;
  assign pix_we      = pix_we_q;
  assign pix_waddr   = pix_waddr_q;
  assign pix_re      = pix_re_q;
  assign pix_raddr   = pix_raddr_q;
  assign load_done   = load_done_q;
  assign unload_done = unload_done_q;
  assign frame_err   = frame_err_q;

endmodule
